// File: rtl/generic_fifo_rd_stream.sv
// Read-side streamer for a dual-clock FIFO. It issues memory reads, tracks
// the reads still in the memory pipeline and holds the returned words in a
// small in-order buffer. A valid/ready stream drains that buffer.
module generic_fifo_rd_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clka,
  input  logic                  reseta,
  input  logic                  emptya,
  output logic                  rd_op,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_level
);

  // One buffer slot per cycle of memory latency, plus one slot so that
  // reads can keep streaming while the head word is being consumed.
  localparam int         DEPTH    = MEM_LATENCY + 1;
  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);
  localparam logic [1:0] DEPTH_L  = 2'(DEPTH);
  localparam logic [2:0] DEPTH_W  = 3'(DEPTH);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 2) begin : g_bad_latency
    $error("generic_fifo_rd_stream: MEM_LATENCY must be 1 or 2");
  end

  logic [MEM_LATENCY-1:0] valid_pipe;
  logic [MEM_LATENCY-1:0] pipe_next;
  logic [DATA_WIDTH-1:0]  buf_mem [4];
  logic [1:0]             wr_ptr;
  logic [1:0]             rd_ptr;
  logic [1:0]             level;
  logic [1:0]             in_flight;
  logic [2:0]             committed;
  logic                   push;
  logic                   pop;

  // Pointers wrap modulo DEPTH, which is 3 (not a power of two) for latency 2.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Count reads that have been issued but whose data has not been buffered.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      in_flight = in_flight + 2'(valid_pipe[i]);
    end
  end

  // Next value of the in-flight shift register: a new read enters stage 0.
  always_comb begin
    pipe_next    = '0;
    pipe_next[0] = rd_op;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_next[i] = valid_pipe[i-1];
    end
  end

  // Issue a read only when every word already promised (buffered or in
  // flight, less the one leaving now) still leaves a free slot.
  always_comb begin
    out_valid = (level != 2'd0);
    out_data  = out_valid ? buf_mem[rd_ptr] : '0;
    pop       = out_valid && out_ready;
    push      = valid_pipe[MEM_LATENCY-1] && !flush;
    committed = {1'b0, level} + {1'b0, in_flight} - {2'b00, pop};
    rd_op     = !emptya && !flush && !reseta && (committed < DEPTH_W);
  end

  assign out_level = level;

  // Buffer bookkeeping; flush and reset both drop buffered and in-flight data.
  always_ff @(posedge clka or posedge reseta) begin
    if (reseta) begin
      valid_pipe <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else if (flush) begin
      valid_pipe <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      valid_pipe <= pipe_next;
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      level <= level + 2'(push) - 2'(pop);
    end
  end

  // Returned memory data lands at the buffer tail; storage needs no reset
  // because the head is masked whenever the buffer is empty.
  always_ff @(posedge clka) begin
    if (push) begin
      buf_mem[wr_ptr] <= mem_rd_data;
    end
  end

  // The read throttle must make a push onto a full buffer impossible.
  overflow_chk : assert property (@(posedge clka) disable iff (reseta)
                                  !(push && (level == DEPTH_L)));

endmodule

// File: tb/tb_generic_fifo_rd_stream.sv
// Bench for generic_fifo_rd_stream: one instance with MEM_LATENCY=1 and one
// with MEM_LATENCY=2, both DATA_WIDTH=8, sharing one clock. Only the selected
// instance is active; the other sits in reset.
module tb_generic_fifo_rd_stream;

  logic       clka = 1'b0;
  logic       reseta      [2];
  logic       emptya      [2];
  logic       flush       [2];
  logic       out_ready   [2];
  logic [7:0] mem_rd_data [2];
  logic       rd_op       [2];
  logic       out_valid   [2];
  logic [7:0] out_data    [2];
  logic [1:0] out_level   [2];

  always #5 clka = ~clka;

  generic_fifo_rd_stream #(.DATA_WIDTH(8), .MEM_LATENCY(1)) dut_l1 (
    .clka(clka), .reseta(reseta[0]), .emptya(emptya[0]), .rd_op(rd_op[0]),
    .mem_rd_data(mem_rd_data[0]), .flush(flush[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_level(out_level[0])
  );

  generic_fifo_rd_stream #(.DATA_WIDTH(8), .MEM_LATENCY(2)) dut_l2 (
    .clka(clka), .reseta(reseta[1]), .emptya(emptya[1]), .rd_op(rd_op[1]),
    .mem_rd_data(mem_rd_data[1]), .flush(flush[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_level(out_level[1])
  );

  typedef struct {
    logic       rst;
    logic       emp;
    logic       fl;
    logic       rdy;
    logic [7:0] mem;
    logic       e_rd;
    logic       e_val;
    logic [7:0] e_data;
    logic [1:0] e_lvl;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } fly_t;

  vec_t       tbl[$];
  logic [7:0] src_q[$];
  logic [7:0] mdl_buf[$];
  logic [7:0] delivered[$];
  fly_t       mdl_fly[$];
  fly_t       env_ret[$];
  int         cur = 0;
  int         ml = 1;
  int         dd = 2;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  // One comparison: count it, and report it if the values differ.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (inst %0d, cycle %0d)",
               name, act, exp, cur, cyc);
    end
  endtask

  task automatic driveInputs(input logic rst, input logic emp, input logic fl,
                             input logic rdy, input logic [7:0] md);
    reseta[cur]      = rst;
    emptya[cur]      = emp;
    flush[cur]       = fl;
    out_ready[cur]   = rdy;
    mem_rd_data[cur] = md;
  endtask

  task automatic checkOutput(input logic e_rd, input logic e_val, input logic [7:0] e_data,
                             input logic [1:0] e_lvl, input string tag);
    chk({tag, "_rd_op"},     32'(rd_op[cur]),     32'(e_rd));
    chk({tag, "_out_valid"}, 32'(out_valid[cur]), 32'(e_val));
    chk({tag, "_out_data"},  32'(out_data[cur]),  32'(e_data));
    chk({tag, "_out_level"}, 32'(out_level[cur]), 32'(e_lvl));
  endtask

  task automatic addVec(input logic rst, input logic emp, input logic fl, input logic rdy,
                        input logic [7:0] mem, input logic e_rd, input logic e_val,
                        input logic [7:0] e_data, input logic [1:0] e_lvl);
    vec_t v;
    v.rst = rst; v.emp = emp; v.fl = fl; v.rdy = rdy; v.mem = mem;
    v.e_rd = e_rd; v.e_val = e_val; v.e_data = e_data; v.e_lvl = e_lvl;
    tbl.push_back(v);
  endtask

  task automatic loadSrc(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(first + 8'(i));
    end
  endtask

  // Hold reset for a few cycles, checking outputs clear without a clock edge.
  task automatic doReset(input int ncyc);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput(1'b0, 1'b0, 8'h00, 2'd0, "reset_async");
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clka);
      checkOutput(1'b0, 1'b0, 8'h00, 2'd0, "reset_hold");
      @(posedge clka);
      cyc++;
      #1;
    end
    mdl_buf.delete();
    mdl_fly.delete();
    delivered.delete();
  endtask

  task automatic startInstance(input int c);
    reseta[cur] = 1'b1;
    cur = c;
    ml  = c + 1;
    dd  = ml + 1;
    src_q.delete();
    env_ret.delete();
    doReset(2);
  endtask

  // One cycle against the reference model: the memory returns each read
  // word ml cycles after its rd_op; the buffer is an ideal queue of dd words.
  task automatic applyStimulus(input logic fl, input logic rdy, input logic gate);
    logic       emp, pop, exp_rd, act_rd, act_pop;
    logic [7:0] md, act_dat, w;
    fly_t       f;
    while (env_ret.size() > 0 && env_ret[0].due < cyc) void'(env_ret.pop_front());
    md = 8'($urandom);
    if (env_ret.size() > 0 && env_ret[0].due == cyc) md = env_ret[0].data;
    emp = gate || (src_q.size() == 0);
    driveInputs(1'b0, emp, fl, rdy, md);
    @(negedge clka);
    pop    = (mdl_buf.size() != 0) && rdy;
    exp_rd = !emp && !fl && ((mdl_buf.size() + mdl_fly.size() - int'(pop)) < dd);
    checkOutput(exp_rd, mdl_buf.size() != 0, (mdl_buf.size() != 0) ? mdl_buf[0] : 8'h00,
                2'(mdl_buf.size()), "stream");
    act_rd  = rd_op[cur];
    act_pop = out_valid[cur] && rdy;
    act_dat = out_data[cur];
    @(posedge clka);
    if (act_pop) delivered.push_back(act_dat);
    if (fl) begin
      mdl_buf.delete();
      mdl_fly.delete();
    end else begin
      if (pop) void'(mdl_buf.pop_front());
      if (mdl_fly.size() > 0 && mdl_fly[0].due == cyc) begin
        f = mdl_fly.pop_front();
        mdl_buf.push_back(f.data);
      end
    end
    if (act_rd && src_q.size() > 0) begin
      w = src_q.pop_front();
      f.data = w;
      f.due  = cyc + ml;
      env_ret.push_back(f);
      if (!fl) mdl_fly.push_back(f);
    end
    cyc++;
    #1;
  endtask

  task automatic checkDelivered(input string name, input logic [7:0] first, input int n);
    chk({name, "_count"}, 32'(delivered.size()), 32'(n));
    for (int i = 0; i < n && i < delivered.size(); i++) begin
      chk({name, "_word"}, 32'(delivered[i]), 32'(first + 8'(i)));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reseta[i] = 1'b1; emptya[i] = 1'b1; flush[i] = 1'b0;
      out_ready[i] = 1'b0; mem_rd_data[i] = 8'h00;
    end

    // Cycle vectors for the latency-1 instance: reset, single word, flush.
    //     rst   emp   fl    rdy   mem    rd    val   data   lvl
    addVec(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    addVec(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 2'd1);
    addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 2'd0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 1'b0, 1'b1, 8'h77, 2'd1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 8'h77, 2'd2);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 2'd2);
    addVec(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    addVec(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd0);

    cur = 0;
    foreach (tbl[i]) begin
      driveInputs(tbl[i].rst, tbl[i].emp, tbl[i].fl, tbl[i].rdy, tbl[i].mem);
      @(negedge clka);
      checkOutput(tbl[i].e_rd, tbl[i].e_val, tbl[i].e_data, tbl[i].e_lvl, "vec");
      @(posedge clka);
      cyc++;
      #1;
    end

    // Streaming eight words with the sink always ready.
    startInstance(0);
    loadSrc(8'h01, 8);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
    checkDelivered("stream8", 8'h01, 8);

    // Backpressure: the buffer fills to two, then drains in order.
    delivered.delete();
    loadSrc(8'h20, 5);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    chk("bp_level_full", 32'(out_level[cur]), 32'd2);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
    checkDelivered("backpressure", 8'h20, 5);

    // Flush with two buffered words and one read still in the memory.
    startInstance(1);
    loadSrc(8'h40, 6);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    chk("flush_pre_level", 32'(out_level[cur]), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    chk("flush_post_valid", 32'(out_valid[cur]), 32'd0);
    chk("flush_post_level", 32'(out_level[cur]), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
    checkDelivered("after_flush", 8'h43, 3);

    // Latency 2, ten words, sink alternating ready and stalled.
    delivered.delete();
    loadSrc(8'h60, 10);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0);
    checkDelivered("toggle10", 8'h60, 10);

    // Random traffic on both latencies, with a reset in the middle.
    for (int inst = 0; inst < 2; inst++) begin
      startInstance(inst);
      for (int i = 0; i < 300; i++) begin
        if (src_q.size() < 4 && ($urandom % 4) == 0) loadSrc(8'($urandom), 3);
        if (i == 150) doReset(2);
        applyStimulus(($urandom % 20) == 0, ($urandom % 3) != 0, ($urandom % 5) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
